// File: rtl/lud_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lud_seq_pkg
// Purpose  : Shared types, constants and entry-field helpers for the
//            LU-decomposition control-word sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package lud_seq_pkg;

  // Sequencer states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } seq_state_e;

  // Widest program entry the helpers can handle; callers size-cast in and out
  localparam int unsigned ENTRY_MAX_W = 512;

  // The NOP word: every write-enable and select bit is zero
  localparam logic [ENTRY_MAX_W-1:0] NOP = '0;

  // Control-word field of an entry {ctrl_word, rpt}; rpt occupies the LSBs
  function automatic logic [ENTRY_MAX_W-1:0] entry_ctrl(
    input logic [ENTRY_MAX_W-1:0] entry,
    input int unsigned            rpt_w
  );
    return entry >> rpt_w;
  endfunction

  // Repeat-count field of an entry
  function automatic logic [ENTRY_MAX_W-1:0] entry_rpt(
    input logic [ENTRY_MAX_W-1:0] entry,
    input int unsigned            rpt_w
  );
    logic [ENTRY_MAX_W-1:0] mask;
    mask = ~({ENTRY_MAX_W{1'b1}} << rpt_w);
    return entry & mask;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lud_prog_store.sv
`default_nettype none
// ============================================================================
// Module   : lud_prog_store
// Purpose  : Program store: one synchronous write port, one asynchronous read
//            port. No reset, so contents survive a reset of the sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module lud_prog_store #(
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 68
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Write port
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule
`default_nettype wire

// File: rtl/lud_ctrl_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : lud_ctrl_sequencer
// Purpose  : Issues a preloaded schedule of {ctrl_word, rpt} entries on
//            CTRL_Signal, each for rpt+1 cycles, then drains the MAC/DIV
//            pipelines with NOPs before pulsing done.
// Options  : LUD_SEQ_LOOP_EN - adds loop_mode / iter_cnt for repeated passes.
// Revision : 1.0 - initial release
// ============================================================================
module lud_ctrl_sequencer
  import lud_seq_pkg::*;
#(
  parameter int unsigned CTRL_WIDTH   = 60,
  parameter int unsigned PROG_DEPTH   = 256,
  parameter int unsigned PC_WIDTH     = $clog2(PROG_DEPTH),
  parameter int unsigned RPT_WIDTH    = 8,
  parameter int unsigned DRAIN_CYCLES = 16
) (
  input  logic                          CLK_100,
  input  logic                          locked,
  input  logic                          prog_we,
  input  logic [PC_WIDTH-1:0]           prog_addr,
  input  logic [CTRL_WIDTH+RPT_WIDTH-1:0] prog_din,
  input  logic [PC_WIDTH:0]             prog_len,
  input  logic                          start,
  input  logic                          pause,
  input  logic                          abort,
`ifdef LUD_SEQ_LOOP_EN
  input  logic                          loop_mode,
  output logic [15:0]                   iter_cnt,
`endif
  output logic [CTRL_WIDTH-1:0]         CTRL_Signal,
  output logic                          busy,
  output logic                          done,
  output logic                          aborted,
  output logic                          prog_err,
  output logic [PC_WIDTH-1:0]           pc
);

  localparam int unsigned ENTRY_W = CTRL_WIDTH + RPT_WIDTH;
  localparam int unsigned LEN_W   = PC_WIDTH + 1;
  localparam int unsigned DRN_W   = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  seq_state_e             state_q, state_d;
  logic [CTRL_WIDTH-1:0]  ctrl_q, ctrl_d;
  logic [CTRL_WIDTH-1:0]  word_q, word_d;   // word currently scheduled, kept across pause
  logic [PC_WIDTH-1:0]    pc_q, pc_d;
  logic [RPT_WIDTH-1:0]   rpt_q, rpt_d;
  logic [LEN_W-1:0]       len_q, len_d;
  logic [DRN_W-1:0]       drn_q, drn_d;
  logic                   done_q, done_d;
  logic                   aborted_q, aborted_d;
  logic                   err_q, err_d;
`ifdef LUD_SEQ_LOOP_EN
  logic [15:0]            iter_q, iter_d;
`endif

  logic                   w_last;
  logic                   w_len_ok;
  logic                   w_we;
  logic [PC_WIDTH-1:0]    w_rd_addr;
  logic [ENTRY_W-1:0]     w_rd_data;
  logic [CTRL_WIDTH-1:0]  w_rd_ctrl;
  logic [RPT_WIDTH-1:0]   w_rd_rpt;

  // Current entry is the last one of the schedule
  assign w_last   = ({1'b0, pc_q} + LEN_W'(1)) == len_q;
  assign w_len_ok = (prog_len != '0) && (prog_len <= LEN_W'(PROG_DEPTH));

  // Writes only while idle so a running schedule cannot be corrupted
  assign w_we = prog_we && (state_q == IDLE);

  // Read the entry that will be loaded at the next edge: entry 0 on start or
  // loop wrap, otherwise the successor of the current entry
  assign w_rd_addr = ((state_q == RUN) && !w_last) ? (pc_q + PC_WIDTH'(1)) : '0;

  lud_prog_store #(
    .DEPTH  (PROG_DEPTH),
    .ADDR_W (PC_WIDTH),
    .DATA_W (ENTRY_W)
  ) u_store (
    .clk     (CLK_100),
    .we_i    (w_we),
    .waddr_i (prog_addr),
    .wdata_i (prog_din),
    .raddr_i (w_rd_addr),
    .rdata_o (w_rd_data)
  );

  assign w_rd_ctrl = CTRL_WIDTH'(entry_ctrl(ENTRY_MAX_W'(w_rd_data), RPT_WIDTH));
  assign w_rd_rpt  = RPT_WIDTH'(entry_rpt(ENTRY_MAX_W'(w_rd_data), RPT_WIDTH));

  // Next-state and registered-output logic
  always_comb begin
    state_d   = state_q;
    ctrl_d    = ctrl_q;
    word_d    = word_q;
    pc_d      = pc_q;
    rpt_d     = rpt_q;
    len_d     = len_q;
    drn_d     = drn_q;
    done_d    = 1'b0;
    aborted_d = 1'b0;
    err_d     = err_q;
`ifdef LUD_SEQ_LOOP_EN
    iter_d    = iter_q;
`endif
    unique case (state_q)
      IDLE: begin
        ctrl_d = CTRL_WIDTH'(NOP);
        if (start) begin
          if (w_len_ok) begin
            state_d = RUN;
            pc_d    = '0;
            len_d   = prog_len;
            rpt_d   = w_rd_rpt;
            ctrl_d  = w_rd_ctrl;
            word_d  = w_rd_ctrl;
            err_d   = 1'b0;
`ifdef LUD_SEQ_LOOP_EN
            iter_d  = '0;
`endif
          end else begin
            err_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (abort) begin
          state_d   = IDLE;
          ctrl_d    = CTRL_WIDTH'(NOP);
          aborted_d = 1'b1;
        end else if (pause) begin
          ctrl_d = CTRL_WIDTH'(NOP);
        end else if (rpt_q != '0) begin
          rpt_d  = rpt_q - RPT_WIDTH'(1);
          ctrl_d = word_q;
        end else if (!w_last) begin
          pc_d   = pc_q + PC_WIDTH'(1);
          rpt_d  = w_rd_rpt;
          ctrl_d = w_rd_ctrl;
          word_d = w_rd_ctrl;
`ifdef LUD_SEQ_LOOP_EN
        end else if (loop_mode) begin
          pc_d   = '0;
          rpt_d  = w_rd_rpt;
          ctrl_d = w_rd_ctrl;
          word_d = w_rd_ctrl;
          if (iter_q != 16'hFFFF) begin
            iter_d = iter_q + 16'd1;
          end
`endif
        end else begin
          state_d = DRAIN;
          ctrl_d  = CTRL_WIDTH'(NOP);
          drn_d   = DRN_W'(DRAIN_CYCLES - 1);
        end
      end
      DRAIN: begin
        ctrl_d = CTRL_WIDTH'(NOP);
        if (abort) begin
          state_d   = IDLE;
          aborted_d = 1'b1;
        end else if (drn_q == '0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          drn_d = drn_q - DRN_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        ctrl_d  = CTRL_WIDTH'(NOP);
      end
    endcase
  end

  // State and output registers, asynchronously cleared by locked low
  always_ff @(posedge CLK_100 or negedge locked) begin
    if (!locked) begin
      state_q   <= IDLE;
      ctrl_q    <= '0;
      word_q    <= '0;
      pc_q      <= '0;
      rpt_q     <= '0;
      len_q     <= '0;
      drn_q     <= '0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      err_q     <= 1'b0;
`ifdef LUD_SEQ_LOOP_EN
      iter_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      ctrl_q    <= ctrl_d;
      word_q    <= word_d;
      pc_q      <= pc_d;
      rpt_q     <= rpt_d;
      len_q     <= len_d;
      drn_q     <= drn_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
      err_q     <= err_d;
`ifdef LUD_SEQ_LOOP_EN
      iter_q    <= iter_d;
`endif
    end
  end

  assign CTRL_Signal = ctrl_q;
  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign aborted     = aborted_q;
  assign prog_err    = err_q;
  assign pc          = pc_q;
`ifdef LUD_SEQ_LOOP_EN
  assign iter_cnt    = iter_q;
`endif

endmodule
`default_nettype wire
